// File: rtl/comparador_pkg.sv
// Shared definitions for the bit-serial magnitude comparator:
// FSM state encoding, result codes and the bit-counter width helper.
package comparador_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COMPARA = 1'b1
  } state_t;

  // Result codes carried while a comparison is in flight.
  localparam logic [1:0] RES_NONE = 2'd0;
  localparam logic [1:0] RES_EQ   = 2'd1;
  localparam logic [1:0] RES_GT   = 2'd2;
  localparam logic [1:0] RES_LT   = 2'd3;

  // Bits needed to hold the counter value WIDTH-1 (never less than one bit).
  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/comparador_bit.sv
// Single-bit comparison cell: reports whether the two bits differ and, if so,
// whether A wins. In signed mode the sign bit has inverted sense.
module comparador_bit (
  input  logic a_bit,
  input  logic b_bit,
  input  logic is_sign,
  input  logic signed_mode,
  output logic differ,
  output logic a_greater
);

  logic w_invert;

  assign w_invert  = is_sign & signed_mode;
  assign differ    = a_bit ^ b_bit;
  // A sign bit of 1 means a negative value, so A is smaller there.
  assign a_greater = w_invert ? (~a_bit & b_bit) : (a_bit & ~b_bit);

endmodule

// File: rtl/comparador_magnitude_serial.sv
// Bit-serial MSB-first magnitude comparator.
// Optional build macro EARLY_EXIT_EN: stop on the first differing bit instead
// of always walking all WIDTH bits (flag values are the same either way).
module comparador_magnitude_serial
  import comparador_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             aeqb,
  output logic             agtb,
  output logic             altb
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [CW-1:0]    r_cnt;
  logic             r_decided;
  logic [1:0]       r_res;
  logic             r_done;
  logic             r_aeqb;
  logic             r_agtb;
  logic             r_altb;

  logic             w_busy;
  logic             w_load;
  logic             w_terminate;
  logic             w_differ;
  logic             w_a_greater;
  logic             w_is_sign;
  logic             w_last;
  logic             w_stop;
  logic             w_signed_mode;
  logic [1:0]       w_bit_res;
  logic [1:0]       w_final_res;

  assign w_signed_mode = (SIGNED != 0);
  // The sign bit is examined on the first COMPARA cycle, while the counter is still full.
  assign w_is_sign     = (r_cnt == CNT_LOAD);
  assign w_last        = (r_cnt == '0);
  assign w_bit_res     = w_a_greater ? RES_GT : RES_LT;
  // A decision already taken wins over anything seen in later bits.
  assign w_final_res   = r_decided ? r_res : (w_differ ? w_bit_res : RES_EQ);

`ifdef EARLY_EXIT_EN
  assign w_stop = w_last | w_differ | r_decided;
`else
  assign w_stop = w_last;
`endif

  comparador_bit u_bit (
    .a_bit       (r_a[WIDTH-1]),
    .b_bit       (r_b[WIDTH-1]),
    .is_sign     (w_is_sign),
    .signed_mode (w_signed_mode),
    .differ      (w_differ),
    .a_greater   (w_a_greater)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state and control decode; start is only honoured in IDLE.
  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    w_load       = 1'b0;
    w_terminate  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_load       = 1'b1;
          w_state_next = ST_COMPARA;
        end
      end
      ST_COMPARA: begin
        w_busy = 1'b1;
        if (w_stop) begin
          w_terminate  = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Operand shift registers, bit counter and sticky decision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_cnt     <= '0;
      r_decided <= 1'b0;
      r_res     <= RES_NONE;
    end else if (w_load) begin
      r_a       <= a;
      r_b       <= b;
      r_cnt     <= CNT_LOAD;
      r_decided <= 1'b0;
      r_res     <= RES_NONE;
    end else if (r_state == ST_COMPARA) begin
      r_a <= {r_a[WIDTH-2:0], 1'b0};
      r_b <= {r_b[WIDTH-2:0], 1'b0};
      if (!w_last) r_cnt <= r_cnt - CW'(1);
      if (!r_decided && w_differ) begin
        r_decided <= 1'b1;
        r_res     <= w_bit_res;
      end
    end
  end

  // Result flags and done pulse, updated only on the terminating edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done <= 1'b0;
      r_aeqb <= 1'b0;
      r_agtb <= 1'b0;
      r_altb <= 1'b0;
    end else begin
      r_done <= w_terminate;
      if (w_terminate) begin
        r_aeqb <= (w_final_res == RES_EQ);
        r_agtb <= (w_final_res == RES_GT);
        r_altb <= (w_final_res == RES_LT);
      end
    end
  end

  assign busy = w_busy;
  assign done = r_done;
  assign aeqb = r_aeqb;
  assign agtb = r_agtb;
  assign altb = r_altb;

endmodule

// File: tb/tb_comparador_magnitude_serial.sv
// Directed bench for the serial comparator: one unsigned and one signed
// instance at WIDTH=4, a vector table plus hand-written corner sequences.
module tb_comparador_magnitude_serial;

  localparam int W  = 4;
  localparam int EQ = 4;  // {aeqb,agtb,altb}
  localparam int GT = 2;
  localparam int LT = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [1:0]   start_v;
  logic [W-1:0] a_v [2];
  logic [W-1:0] b_v [2];
  logic [1:0]   busy_v, done_v, eq_v, gt_v, lt_v;

  int n_tests = 0;
  int n_fail  = 0;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      comparador_magnitude_serial #(.WIDTH(W), .SIGNED(gi)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (start_v[gi]),
        .a     (a_v[gi]),
        .b     (b_v[gi]),
        .busy  (busy_v[gi]),
        .done  (done_v[gi]),
        .aeqb  (eq_v[gi]),
        .agtb  (gt_v[gi]),
        .altb  (lt_v[gi])
      );
    end
  endgenerate

  typedef struct {
    int a;
    int b;
    int s;      // 0 = unsigned instance, 1 = signed instance
    int flags;  // expected {aeqb,agtb,altb}
    int lat_e;  // done after this edge with early exit
    int lat_f;  // done after this edge without early exit
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int flags_of(input int s);
    return int'({eq_v[s], gt_v[s], lt_v[s]});
  endfunction

  function automatic int exp_lat(input int e, input int f);
`ifdef EARLY_EXIT_EN
    return e;
`else
    return f;
`endif
  endfunction

  // Present start for one edge (edge 0), then scramble the operand inputs.
  task automatic launch(input int s, input int a, input int b);
    @(negedge clk);
    a_v[s]     = W'(a);
    b_v[s]     = W'(b);
    start_v[s] = 1'b1;
    @(posedge clk);
    #1;
    start_v[s] = 1'b0;
    a_v[s]     = ~W'(a);
    b_v[s]     = ~W'(b);
  endtask

  // Count edges until done; busy must be high in every cycle before done.
  task automatic wait_done(input int s, output int n, output int busy_bad);
    n = 0;
    busy_bad = 0;
    while (!done_v[s] && n < 20) begin
      if (!busy_v[s]) busy_bad++;
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  int n, busy_bad, bad, ex;

  initial begin
    vecs[0]  = '{a: 5,  b: 5,  s: 0, flags: EQ, lat_e: 4, lat_f: 4};
    vecs[1]  = '{a: 10, b: 5,  s: 0, flags: GT, lat_e: 1, lat_f: 4};
    vecs[2]  = '{a: 10, b: 12, s: 0, flags: LT, lat_e: 2, lat_f: 4};
    vecs[3]  = '{a: 15, b: 3,  s: 0, flags: GT, lat_e: 1, lat_f: 4};
    vecs[4]  = '{a: 15, b: 3,  s: 1, flags: LT, lat_e: 1, lat_f: 4};
    vecs[5]  = '{a: 12, b: 12, s: 1, flags: EQ, lat_e: 4, lat_f: 4};
    vecs[6]  = '{a: 3,  b: 12, s: 0, flags: LT, lat_e: 1, lat_f: 4};
    vecs[7]  = '{a: 0,  b: 15, s: 1, flags: GT, lat_e: 1, lat_f: 4};
    vecs[8]  = '{a: 8,  b: 7,  s: 1, flags: LT, lat_e: 1, lat_f: 4};
    vecs[9]  = '{a: 6,  b: 7,  s: 1, flags: LT, lat_e: 4, lat_f: 4};
    vecs[10] = '{a: 9,  b: 8,  s: 0, flags: GT, lat_e: 4, lat_f: 4};
    vecs[11] = '{a: 0,  b: 0,  s: 0, flags: EQ, lat_e: 4, lat_f: 4};

    rst     = 1'b1;
    start_v = '0;
    for (int i = 0; i < 2; i++) begin
      a_v[i] = '0;
      b_v[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++)
      check($sformatf("reset_outputs_s%0d", s),
            int'({busy_v[s], done_v[s], eq_v[s], gt_v[s], lt_v[s]}), 0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors.
    for (int i = 0; i < 12; i++) begin
      launch(vecs[i].s, vecs[i].a, vecs[i].b);
      wait_done(vecs[i].s, n, busy_bad);
      check($sformatf("v%0d_latency", i), n, exp_lat(vecs[i].lat_e, vecs[i].lat_f));
      check($sformatf("v%0d_busy_before_done", i), busy_bad, 0);
      check($sformatf("v%0d_busy_at_done", i), int'(busy_v[vecs[i].s]), 0);
      check($sformatf("v%0d_flags", i), flags_of(vecs[i].s), vecs[i].flags);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_done_single", i), int'(done_v[vecs[i].s]), 0);
      check($sformatf("v%0d_flags_hold", i), flags_of(vecs[i].s), vecs[i].flags);
      $display("[TB] vec %0d: s=%0d a=%0d b=%0d flags=%0d latency=%0d",
               i, vecs[i].s, vecs[i].a, vecs[i].b, flags_of(vecs[i].s), n);
    end

    // Start during an operation is ignored; start in the done cycle is accepted.
    launch(0, 7, 6);
    @(posedge clk);
    #1;
    a_v[0]     = 4'd3;
    b_v[0]     = 4'd12;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    wait_done(0, n, busy_bad);
    check("ignored_start_latency", n, 2);
    check("ignored_start_flags", flags_of(0), GT);
    a_v[0]     = 4'd3;
    b_v[0]     = 4'd12;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    check("b2b_accepted_busy", int'(busy_v[0]), 1);
    wait_done(0, n, busy_bad);
    check("b2b_latency", n, exp_lat(1, 4));
    check("b2b_flags", flags_of(0), LT);
    $display("[TB] back-to-back: flags=%0d latency=%0d", flags_of(0), n);

    // Reset in the middle of an operation aborts it.
    launch(0, 15, 12);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_outputs_zero",
          int'({busy_v[0], done_v[0], eq_v[0], gt_v[0], lt_v[0]}), 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (done_v[0] || busy_v[0] || (flags_of(0) != 0)) bad++;
    end
    check("abort_no_done", bad, 0);
    launch(0, 12, 15);
    wait_done(0, n, busy_bad);
    ex = exp_lat(3, 4);
    check("after_abort_latency", n, ex);
    check("after_abort_flags", flags_of(0), LT);
    $display("[TB] after abort: flags=%0d latency=%0d", flags_of(0), n);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
